// File: rtl/amm_slave_responder_if.sv
// Avalon-MM burst bus between a master and the amm_slave_responder memory model.
// Handshake: a beat transfers on a rising clock edge where (read_i|write_i)=1 and
// waitrequest_o=0; while waitrequest_o=1 the master holds every request input stable.
interface amm_slave_responder_if #(
  parameter int DATA_W      = 32,
  parameter int AMM_ADDR_W  = 32,
  parameter int AMM_BURST_W = 11
);
  localparam int DATA_B_W = DATA_W / 8;

  logic [AMM_ADDR_W-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic [DATA_W-1:0]      writedata_i;
  logic [AMM_BURST_W-1:0] burstcount_i;
  logic [DATA_B_W-1:0]    byteenable_i;
  logic                   waitrequest_o;
  logic [DATA_W-1:0]      readdata_o;
  logic                   readdatavalid_o;
  logic                   protocol_error_o;
  logic [1:0]             dbg_state_o;

  modport slave (
    input  address_i, read_i, write_i, writedata_i, burstcount_i, byteenable_i,
    output waitrequest_o, readdata_o, readdatavalid_o, protocol_error_o, dbg_state_o
  );

  modport master (
    output address_i, read_i, write_i, writedata_i, burstcount_i, byteenable_i,
    input  waitrequest_o, readdata_o, readdatavalid_o, protocol_error_o, dbg_state_o
  );
endinterface

// File: rtl/amm_slave_responder.sv
// Avalon-MM burst slave backed by an internal word array: byte-enabled write bursts,
// fixed-latency read bursts, optional pseudo-random stalls and a sticky protocol error flag.
module amm_slave_responder #(
  parameter int DATA_W       = 32,
  parameter int AMM_ADDR_W   = 32,
  parameter int AMM_BURST_W  = 11,
  parameter int MEM_ADDR_W   = 10,
  parameter int READ_LATENCY = 2,
  parameter int STALL_EN     = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  amm_slave_responder_if.slave amm
);
  localparam int DATA_B_W = DATA_W / 8;
  localparam int ADDR_B_W = (DATA_B_W > 1) ? $clog2(DATA_B_W) : 0;
  localparam int DEPTH    = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} state_t;

  logic [DATA_W-1:0]      r_mem [0:DEPTH-1];
  state_t                 r_state;
  logic [MEM_ADDR_W-1:0]  r_idx;
  logic [AMM_BURST_W-1:0] r_left;
  logic [3:0]             r_lat;
  logic                   r_wait;
  logic                   r_rdv;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_perr;
  logic [7:0]             r_lfsr;
  logic [AMM_ADDR_W-1:0]  r_prev_addr;
  logic [AMM_BURST_W-1:0] r_prev_bc;
  logic [DATA_W-1:0]      r_prev_wdata;
  logic                   r_prev_stalled;

  state_t                 w_state_nxt;
  logic [MEM_ADDR_W-1:0]  w_idx_nxt;
  logic [AMM_BURST_W-1:0] w_left_nxt;
  logic [3:0]             w_lat_nxt;
  logic                   w_we;
  logic [MEM_ADDR_W-1:0]  w_widx;
  logic                   w_present;
  logic [MEM_ADDR_W-1:0]  w_rd_idx;
  logic                   w_perr_set;
  logic                   w_wait_nxt;

  logic                   w_req;
  logic                   w_acc;
  logic [MEM_ADDR_W-1:0]  w_addr_idx;
  logic [AMM_BURST_W-1:0] w_bc;
  logic                   w_changed;
  logic                   w_lfsr_fb;

  assign w_req      = amm.read_i | amm.write_i;
  assign w_acc      = w_req & ~r_wait;
  assign w_addr_idx = amm.address_i[MEM_ADDR_W+ADDR_B_W-1:ADDR_B_W];
  assign w_bc       = (amm.burstcount_i == '0) ? AMM_BURST_W'(1) : amm.burstcount_i;
  assign w_changed  = (amm.address_i != r_prev_addr) | (amm.burstcount_i != r_prev_bc) |
                      (amm.writedata_i != r_prev_wdata);
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_left_nxt  = r_left;
    w_lat_nxt   = r_lat;
    w_we        = 1'b0;
    w_widx      = r_idx;
    w_present   = 1'b0;
    w_rd_idx    = r_idx;
    w_perr_set  = (amm.read_i & amm.write_i) | (r_prev_stalled & w_req & w_changed);

    case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (amm.burstcount_i == '0) w_perr_set = 1'b1;
          if (amm.write_i) begin
            w_we      = 1'b1;
            w_widx    = w_addr_idx;
            w_idx_nxt = w_addr_idx + 1'b1;
            if (w_bc != AMM_BURST_W'(1)) begin
              w_state_nxt = WR_BURST;
              w_left_nxt  = w_bc - 1'b1;
            end
          end else begin
            w_left_nxt = w_bc;
            if (READ_LATENCY == 1) begin
              w_present   = 1'b1;
              w_rd_idx    = w_addr_idx;
              w_state_nxt = RD_DATA;
            end else begin
              w_idx_nxt   = w_addr_idx;
              w_lat_nxt   = 4'(READ_LATENCY - 1);
              w_state_nxt = RD_WAIT;
            end
          end
        end
      end
      WR_BURST: begin
        if (amm.read_i) w_perr_set = 1'b1;
        if (w_acc) begin
          w_we       = 1'b1;
          w_idx_nxt  = r_idx + 1'b1;
          w_left_nxt = r_left - 1'b1;
          if (r_left == AMM_BURST_W'(1)) w_state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (r_lat == 4'd0) begin
          w_present   = 1'b1;
          w_state_nxt = RD_DATA;
        end else begin
          w_lat_nxt = r_lat - 1'b1;
        end
      end
      RD_DATA: begin
        if (r_left == '0) w_state_nxt = IDLE;
        else              w_present   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Presenting a read beat consumes one word: advance the index, count it off.
    if (w_present) begin
      w_idx_nxt  = w_rd_idx + 1'b1;
      w_left_nxt = w_left_nxt - 1'b1;
    end

    w_wait_nxt = ((w_state_nxt == RD_WAIT) || (w_state_nxt == RD_DATA)) ? 1'b1
               : ((STALL_EN != 0) & r_lfsr[0]);
  end

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int k = 0; k < DATA_B_W; k++) begin
        if (amm.byteenable_i[k]) r_mem[w_widx][8*k +: 8] <= amm.writedata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_left         <= '0;
      r_lat          <= '0;
      r_wait         <= 1'b0;
      r_rdv          <= 1'b0;
      r_rdata        <= '0;
      r_perr         <= 1'b0;
      r_lfsr         <= 8'hFF;
      r_prev_addr    <= '0;
      r_prev_bc      <= '0;
      r_prev_wdata   <= '0;
      r_prev_stalled <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_left         <= w_left_nxt;
      r_lat          <= w_lat_nxt;
      r_wait         <= w_wait_nxt;
      r_rdv          <= w_present;
      if (w_present)  r_rdata <= r_mem[w_rd_idx];
      if (w_perr_set) r_perr  <= 1'b1;
      if (STALL_EN != 0) r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      r_prev_addr    <= amm.address_i;
      r_prev_bc      <= amm.burstcount_i;
      r_prev_wdata   <= amm.writedata_i;
      r_prev_stalled <= r_wait & w_req;
    end
  end

  assign amm.waitrequest_o    = r_wait;
  assign amm.readdata_o       = r_rdata;
  assign amm.readdatavalid_o  = r_rdv;
  assign amm.protocol_error_o = r_perr;
  assign amm.dbg_state_o      = r_state;
endmodule

// File: tb/tb_amm_slave_responder.sv
// Bench for amm_slave_responder: two instances (no stalls / LFSR stalls) driven by directed
// bursts, a queue-based memory and timing model checked every cycle, plus literal expectations.
module tb_amm_slave_responder;
  localparam int DEPTH = 16;
  localparam int LAT0  = 2;
  localparam int LAT1  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic [31:0] drv_addr;
  logic [31:0] drv_wdata;
  logic        drv_read;
  logic        drv_write;
  logic [10:0] drv_burst;
  logic [3:0]  drv_be;
  logic        w_wait;

  amm_slave_responder_if #(.DATA_W(32), .AMM_ADDR_W(32), .AMM_BURST_W(11)) bus0 ();
  amm_slave_responder_if #(.DATA_W(32), .AMM_ADDR_W(32), .AMM_BURST_W(11)) bus1 ();

  assign bus0.address_i    = drv_addr;
  assign bus0.writedata_i  = drv_wdata;
  assign bus0.burstcount_i = drv_burst;
  assign bus0.byteenable_i = drv_be;
  assign bus0.read_i       = drv_read  & ~sel;
  assign bus0.write_i      = drv_write & ~sel;
  assign bus1.address_i    = drv_addr;
  assign bus1.writedata_i  = drv_wdata;
  assign bus1.burstcount_i = drv_burst;
  assign bus1.byteenable_i = drv_be;
  assign bus1.read_i       = drv_read  & sel;
  assign bus1.write_i      = drv_write & sel;
  assign w_wait = sel ? bus1.waitrequest_o : bus0.waitrequest_o;

  amm_slave_responder #(.DATA_W(32), .AMM_ADDR_W(32), .AMM_BURST_W(11), .MEM_ADDR_W(4),
                        .READ_LATENCY(LAT0), .STALL_EN(0))
    dut0 (.clk_i(clk), .rst_n_i(rst_n), .amm(bus0.slave));
  amm_slave_responder #(.DATA_W(32), .AMM_ADDR_W(32), .AMM_BURST_W(11), .MEM_ADDR_W(4),
                        .READ_LATENCY(LAT1), .STALL_EN(1))
    dut1 (.clk_i(clk), .rst_n_i(rst_n), .amm(bus1.slave));

  // ---------------- model state / scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_until = -1;
  int          wr_left = 0;
  int          wr_idx = 0;
  logic        perr_m [2];
  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] exp_q[$];
  int          exp_cyc[$];
  logic [31:0] cap_q[$];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_be [16];
  logic [31:0] stall_data [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    return (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF;
  endfunction

  // Behavioural model: sees every accepted beat and derives memory and read timing.
  initial begin
    perr_m[0] = 1'b0;
    perr_m[1] = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        exp_cyc.delete();
        busy_until = -1;
        wr_left    = 0;
        perr_m[0]  = 1'b0;
        perr_m[1]  = 1'b0;
      end else begin
        int d;
        int idx;
        int bc;
        d = sel ? 1 : 0;
        if (drv_read && drv_write) perr_m[d] = 1'b1;
        if ((drv_read || drv_write) && !w_wait) begin
          if (wr_left > 0) begin
            if (drv_read) perr_m[d] = 1'b1;
            for (int k = 0; k < 4; k++)
              if (drv_be[k]) mem_m[d][wr_idx][8*k +: 8] = drv_wdata[8*k +: 8];
            wr_idx  = (wr_idx + 1) % DEPTH;
            wr_left = wr_left - 1;
          end else begin
            bc  = (drv_burst == 0) ? 1 : int'(drv_burst);
            idx = int'(drv_addr[5:2]);
            if (drv_burst == 0) perr_m[d] = 1'b1;
            if (drv_write) begin
              for (int k = 0; k < 4; k++)
                if (drv_be[k]) mem_m[d][idx][8*k +: 8] = drv_wdata[8*k +: 8];
              wr_idx  = (idx + 1) % DEPTH;
              wr_left = bc - 1;
            end else begin
              for (int k = 0; k < bc; k++) begin
                exp_q.push_back(mem_m[d][(idx + k) % DEPTH]);
                exp_cyc.push_back(cyc + (d ? LAT1 : LAT0) + k);
              end
              busy_until = cyc + (d ? LAT1 : LAT0) + bc - 1;
            end
          end
        end
      end
    end
  end

  // Compare process: checks outputs against the model on every cycle out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic        rdv;
        logic [31:0] rdata;
        logic        wt;
        logic        perr;
        rdv   = sel ? bus1.readdatavalid_o  : bus0.readdatavalid_o;
        rdata = sel ? bus1.readdata_o       : bus0.readdata_o;
        wt    = sel ? bus1.waitrequest_o    : bus0.waitrequest_o;
        perr  = sel ? bus1.protocol_error_o : bus0.protocol_error_o;
        if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
          check("rdv_beat", 32'(rdv), 32'd1);
          check("rdata_beat", rdata, exp_q[0]);
          void'(exp_q.pop_front());
          void'(exp_cyc.pop_front());
        end else begin
          check("rdv_idle", 32'(rdv), 32'd0);
        end
        if (cyc <= busy_until)  check("wait_busy", 32'(wt), 32'd1);
        else if (!sel)          check("wait_idle", 32'(wt), 32'd0);
        check("perr_model", 32'(perr), 32'(perr_m[sel ? 1 : 0]));
        check("rdv_unselected", 32'(sel ? bus0.readdatavalid_o : bus1.readdatavalid_o), 32'd0);
        if (rdv) cap_q.push_back(rdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_beat(input string name);
    int n = 0;
    while (w_wait && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_accept actual=stalled required=accepted", name);
    end
    @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic write_burst(input int d, input logic [31:0] addr, input int bc, input int nbeats);
    sel       = (d != 0);
    drv_addr  = addr;
    drv_burst = 11'(bc);
    drv_read  = 1'b0;
    drv_write = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      drv_wdata = wr_data[i];
      drv_be    = wr_be[i];
      do_beat("write");
    end
    drv_write = 1'b0;
  endtask

  task automatic read_burst(input int d, input logic [31:0] addr, input int bc, input string name);
    int n = 0;
    sel = (d != 0);
    cap_q.delete();
    drv_addr  = addr;
    drv_burst = 11'(bc);
    drv_read  = 1'b1;
    do_beat(name);
    drv_read = 1'b0;
    while (cap_q.size() < bc && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (4) begin @(negedge clk); #1; end
    check({name, "_beats"}, 32'(cap_q.size()), 32'(bc));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    sel = 1'b0; drv_addr = '0; drv_wdata = '0; drv_read = 1'b0; drv_write = 1'b0;
    drv_burst = 11'd1; drv_be = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_wait0", 32'(bus0.waitrequest_o), 32'd0);
    check("reset_rdv0", 32'(bus0.readdatavalid_o), 32'd0);
    check("reset_rdata0", bus0.readdata_o, 32'd0);
    check("reset_perr0", 32'(bus0.protocol_error_o), 32'd0);
    check("reset_wait1", 32'(bus1.waitrequest_o), 32'd0);
    check("reset_rdv1", 32'(bus1.readdatavalid_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); #1; end

    // single write then read
    wr_data[0] = 32'hA5A5_A5A5; wr_be[0] = 4'hF;
    write_burst(0, 32'h10, 1, 1);
    read_burst(0, 32'h10, 1, "t1_read");
    check("t1_data", cap_at(0), 32'hA5A5_A5A5);
    check("t1_wait_after", 32'(bus0.waitrequest_o), 32'd0);

    // burst with partial byteenables over a 0xFFFFFFFF background
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hFFFF_FFFF; wr_be[i] = 4'hF; end
    write_burst(0, 32'h20, 4, 4);
    for (int i = 0; i < 4; i++) wr_data[i] = 32'h1111_1111 * (i + 1);
    wr_be[0] = 4'hC; wr_be[1] = 4'hF; wr_be[2] = 4'hF; wr_be[3] = 4'h3;
    write_burst(0, 32'h20, 4, 4);
    read_burst(0, 32'h20, 4, "t2_read");
    check("t2_beat0", cap_at(0), 32'h1111_FFFF);
    check("t2_beat1", cap_at(1), 32'h2222_2222);
    check("t2_beat2", cap_at(2), 32'h3333_3333);
    check("t2_beat3", cap_at(3), 32'hFFFF_4444);

    // wrap at the top of a 16-word array
    wr_data[0] = 32'hCAFE_000E; wr_data[1] = 32'hCAFE_000F; wr_data[2] = 32'hCAFE_0000;
    for (int i = 0; i < 3; i++) wr_be[i] = 4'hF;
    write_burst(0, 32'h38, 3, 3);
    read_burst(0, 32'h38, 3, "t3_read");
    check("t3_word14", cap_at(0), 32'hCAFE_000E);
    check("t3_word15", cap_at(1), 32'hCAFE_000F);
    check("t3_word0", cap_at(2), 32'hCAFE_0000);
    read_burst(0, 32'h00, 1, "t3_read0");
    check("t3_word0_direct", cap_at(0), 32'hCAFE_0000);

    // stalling instance, burst of 8
    for (int i = 0; i < 8; i++) begin
      stall_data[i] = $urandom_range(32'hFFFF_FFFE, 1);
      wr_data[i] = stall_data[i];
      wr_be[i] = 4'hF;
    end
    write_burst(1, 32'h00, 8, 8);
    read_burst(1, 32'h00, 8, "t4_read");
    for (int i = 0; i < 8; i++) check("t4_readback", cap_at(i), stall_data[i]);
    check("t4_perr", 32'(bus1.protocol_error_o), 32'd0);

    // violations: read and write together, then burstcount 0
    sel = 1'b0;
    check("t5_perr_before", 32'(bus0.protocol_error_o), 32'd0);
    drv_addr = 32'h18; drv_burst = 11'd1; drv_wdata = 32'h0BAD_0006; drv_be = 4'hF;
    drv_read = 1'b1; drv_write = 1'b1;
    do_beat("t5_both");
    drv_read = 1'b0; drv_write = 1'b0;
    check("t5_perr_set", 32'(bus0.protocol_error_o), 32'd1);
    repeat (3) begin @(negedge clk); #1; end
    check("t5_perr_held", 32'(bus0.protocol_error_o), 32'd1);
    wr_data[0] = 32'h5EE0_0005; wr_be[0] = 4'hF;
    write_burst(0, 32'h14, 0, 1);
    read_burst(0, 32'h14, 1, "t5_bc0_read");
    check("t5_bc0_data", cap_at(0), 32'h5EE0_0005);
    read_burst(0, 32'h18, 1, "t5_both_read");
    check("t5_both_data", cap_at(0), 32'h0BAD_0006);
    rst_n = 1'b0;
    #1;
    check("t5_perr_reset", 32'(bus0.protocol_error_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    check("t5_perr_released", 32'(bus0.protocol_error_o), 32'd0);

    // reset during beat 2 of a 4-beat read
    sel = 1'b0;
    cap_q.delete();
    drv_addr = 32'h20; drv_burst = 11'd4; drv_read = 1'b1;
    do_beat("t6_read");
    drv_read = 1'b0;
    n = 0;
    while (cap_q.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
    check("t6_beats_before_reset", 32'(cap_q.size()), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rdv_reset", 32'(bus0.readdatavalid_o), 32'd0);
    check("t6_wait_reset", 32'(bus0.waitrequest_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); #1; end
    read_burst(0, 32'h20, 1, "t6_after");
    check("t6_after_data", cap_at(0), 32'h1111_FFFF);

    repeat (3) begin @(negedge clk); #1; end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
